// File: rtl/tiny8_fetch_pkg.sv
// tiny8_fetch_pkg
//   Shared types for the tiny8 fetch stage: program-counter and instruction
//   word types, the fetch FSM state encoding, the default reset PC and the
//   wrapping PC increment helper.
package tiny8_fetch_pkg;

  typedef logic [7:0] tiny8_pc;
  typedef logic [7:0] tiny8_word;

  typedef enum logic {
    FETCH  = 1'b0,
    ISSUED = 1'b1
  } tiny8_fetch_state;

  localparam tiny8_pc TINY8_RESET_PC = 8'h00;

  // 8-bit unsigned increment; 8'hFF wraps to 8'h00 with no carry out.
  function automatic tiny8_pc tiny8_pc_inc(input tiny8_pc a);
    return a + 8'd1;
  endfunction

endpackage

// File: rtl/tiny8_fetch.sv
// tiny8_fetch
//   Instruction fetch stage for tiny8. Owns the fetch PC, reads one byte per
//   instruction from instruction memory over a req/resp handshake, hands the
//   byte to the IR and holds it there until execute reports exec_done.
//   Branch redirects are applied either to the in-flight read (killing it)
//   or, while an instruction is executing, queued until exec_done.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   mem_read/mem_addr        read request, held until mem_resp
//   mem_resp/mem_rdata       one-cycle response pulse with the byte
//   ir_load/ir_data          IR load strobe and byte (ir_data = mem_rdata)
//   insn_valid/pc            IR holds an unexecuted instruction at pc
//   exec_done                execute finished the instruction in IR
//   redirect/redirect_pc     taken branch and its target
module tiny8_fetch
  import tiny8_fetch_pkg::*;
#(
  parameter tiny8_pc RESET_PC = TINY8_RESET_PC
) (
  input  logic       clk,
  input  logic       rst,
  output logic       mem_read,
  output logic [7:0] mem_addr,
  input  logic       mem_resp,
  input  logic [7:0] mem_rdata,
  output logic       ir_load,
  output logic [7:0] ir_data,
  output logic       insn_valid,
  output logic [7:0] pc,
  input  logic       exec_done,
  input  logic       redirect,
  input  logic [7:0] redirect_pc
);

  tiny8_fetch_state r_state;
  tiny8_pc          r_fetch_pc;
  tiny8_pc          r_pc;
  tiny8_pc          r_tgt;
  logic             r_kill;
  logic             r_pend;
  logic             r_owed;
  logic             r_stale;

  logic w_fetch;
  logic w_issued;
  logic w_drop;
  logic w_load;

  assign w_fetch  = (r_state == FETCH) & ~rst;
  assign w_issued = (r_state == ISSUED) & ~rst;
  // A response is thrown away if the read was killed by an earlier redirect,
  // a redirect arrives with it, or it answers a read abandoned by reset.
  assign w_drop   = mem_resp & (r_kill | redirect | r_stale);
  assign w_load   = w_fetch & mem_resp & ~w_drop;

  assign mem_read   = w_fetch;
  assign mem_addr   = r_fetch_pc;
  assign ir_load    = w_load;
  assign ir_data    = mem_rdata;
  assign insn_valid = w_issued;
  assign pc         = r_pc;

  // Memory still owes a response for a request it has seen. Deliberately not
  // reset: it is what lets the fetch stage recognise a late response to a read
  // that reset abandoned.
  always_ff @(posedge clk) begin
    r_owed <= (r_owed | mem_read) & ~mem_resp;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= FETCH;
      r_fetch_pc <= RESET_PC;
      r_pc       <= RESET_PC;
      r_kill     <= 1'b0;
      r_pend     <= 1'b0;
      r_stale    <= r_owed & ~mem_resp;
    end else begin
      if (mem_resp) begin
        r_stale <= 1'b0;
      end
      unique case (r_state)
        FETCH: begin
          if (mem_resp) begin
            if (w_drop) begin
              // Stale-only drop keeps fetch_pc, re-issuing the same read.
              r_fetch_pc <= redirect ? redirect_pc : (r_kill ? r_tgt : r_fetch_pc);
              r_kill     <= 1'b0;
            end else begin
              r_pc       <= r_fetch_pc;
              r_fetch_pc <= tiny8_pc_inc(r_fetch_pc);
              r_state    <= ISSUED;
            end
          end else if (redirect) begin
            // mem_addr must stay put until the response; remember the target.
            r_kill <= 1'b1;
            r_tgt  <= redirect_pc;
          end
        end
        ISSUED: begin
          if (exec_done) begin
            r_fetch_pc <= redirect ? redirect_pc : (r_pend ? r_tgt : r_fetch_pc);
            r_pend     <= 1'b0;
            r_state    <= FETCH;
          end else if (redirect) begin
            r_pend <= 1'b1;
            r_tgt  <= redirect_pc;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tiny8_fetch.sv
module tb_tiny8_fetch;

  logic       clk;
  logic       rst;
  logic       mem_read;
  logic [7:0] mem_addr;
  logic       mem_resp;
  logic [7:0] mem_rdata;
  logic       ir_load;
  logic [7:0] ir_data;
  logic       insn_valid;
  logic [7:0] pc;
  logic       exec_done;
  logic       redirect;
  logic [7:0] redirect_pc;

  int n_chk;
  int n_fail;

  tiny8_fetch #(.RESET_PC(8'h10)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_read   (mem_read),
    .mem_addr   (mem_addr),
    .mem_resp   (mem_resp),
    .mem_rdata  (mem_rdata),
    .ir_load    (ir_load),
    .ir_data    (ir_data),
    .insn_valid (insn_valid),
    .pc         (pc),
    .exec_done  (exec_done),
    .redirect   (redirect),
    .redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs just after the clock edge; they are consumed at
  // the following edge, and outputs are inspected in between.
  task automatic step(input logic r, input logic rs, input logic [7:0] rd,
                      input logic ed, input logic rdr, input logic [7:0] rp);
    @(posedge clk);
    #1;
    rst         = r;
    mem_resp    = rs;
    mem_rdata   = rd;
    exec_done   = ed;
    redirect    = rdr;
    redirect_pc = rp;
    #1;
  endtask

  // Reference model: fetch address, executing-instruction address, whether
  // the IR is occupied, and every redirect seen since the current read or
  // instruction began (the most recent one is the one that takes effect).
  bit [7:0] m_addr;
  bit [7:0] m_pc;
  bit       m_insn;
  bit [7:0] rq[$];
  bit       mreq;
  int       mwait;
  bit       exp_load;

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1; mem_resp = 1'b0; mem_rdata = 8'h00;
    exec_done = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;

    // Reset, with a response presented during reset to show it is ignored
    step(1, 0, 8'h00, 0, 0, 8'h00);
    chk("rst1_mem_read", mem_read, 0);
    chk("rst1_ir_load", ir_load, 0);
    chk("rst1_insn_valid", insn_valid, 0);
    step(1, 1, 8'hAA, 0, 0, 8'h00);
    chk("rst2_mem_read", mem_read, 0);
    chk("rst2_ir_load", ir_load, 0);
    chk("rst2_insn_valid", insn_valid, 0);

    // Zero-wait stream
    step(0, 1, 8'h41, 0, 0, 8'h00);
    chk("zw0_mem_read", mem_read, 1);
    chk("zw0_mem_addr", mem_addr, 8'h10);
    chk("zw0_ir_load", ir_load, 1);
    chk("zw0_ir_data", ir_data, 8'h41);
    chk("zw0_insn_valid", insn_valid, 0);
    step(0, 0, 8'h00, 0, 0, 8'h00);
    chk("zw1_insn_valid", insn_valid, 1);
    chk("zw1_mem_read", mem_read, 0);
    chk("zw1_pc", pc, 8'h10);
    chk("zw1_ir_load", ir_load, 0);
    step(0, 0, 8'h00, 1, 0, 8'h00);
    chk("zw2_insn_valid", insn_valid, 1);
    step(0, 1, 8'h82, 0, 0, 8'h00);
    chk("zw3_insn_valid", insn_valid, 0);
    chk("zw3_mem_addr", mem_addr, 8'h11);
    chk("zw3_ir_load", ir_load, 1);
    chk("zw3_ir_data", ir_data, 8'h82);
    step(0, 0, 8'h00, 1, 0, 8'h00);
    chk("zw4_pc", pc, 8'h11);
    chk("zw4_insn_valid", insn_valid, 1);

    // Wait states: three cycles without response, then the byte
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 8'h00, 0, 0, 8'h00);
      chk("ws_mem_read", mem_read, 1);
      chk("ws_mem_addr", mem_addr, 8'h12);
      chk("ws_ir_load", ir_load, 0);
    end
    step(0, 1, 8'h33, 0, 0, 8'h00);
    chk("ws_resp_ir_load", ir_load, 1);
    chk("ws_resp_ir_data", ir_data, 8'h33);
    step(0, 0, 8'h00, 1, 0, 8'h00);
    chk("ws_insn_valid", insn_valid, 1);
    chk("ws_pc", pc, 8'h12);

    // Kill of an in-flight read
    step(0, 0, 8'h00, 0, 1, 8'h80);
    chk("kill_addr0", mem_addr, 8'h13);
    step(0, 0, 8'h00, 0, 0, 8'h00);
    chk("kill_addr1", mem_addr, 8'h13);
    chk("kill_read1", mem_read, 1);
    step(0, 1, 8'h99, 0, 0, 8'h00);
    chk("kill_drop_ir_load", ir_load, 0);
    step(0, 1, 8'h5A, 0, 0, 8'h00);
    chk("kill_new_addr", mem_addr, 8'h80);
    chk("kill_new_ir_load", ir_load, 1);
    step(0, 0, 8'h00, 1, 0, 8'h00);
    chk("kill_pc", pc, 8'h80);
    chk("kill_insn_valid", insn_valid, 1);

    // Pending redirect while ISSUED, then redirect coincident with exec_done
    step(0, 1, 8'h01, 0, 0, 8'h00);
    chk("pend_addr81", mem_addr, 8'h81);
    chk("pend_load81", ir_load, 1);
    step(0, 0, 8'h00, 0, 1, 8'h20);
    chk("pend_pc81", pc, 8'h81);
    step(0, 0, 8'h00, 0, 0, 8'h00);
    chk("pend_hold_valid", insn_valid, 1);
    chk("pend_hold_read", mem_read, 0);
    step(0, 0, 8'h00, 1, 0, 8'h00);
    chk("pend_done_valid", insn_valid, 1);
    step(0, 1, 8'h02, 0, 0, 8'h00);
    chk("pend_target_addr", mem_addr, 8'h20);
    chk("pend_target_load", ir_load, 1);
    step(0, 0, 8'h00, 1, 1, 8'h30);
    chk("coin_pc", pc, 8'h20);
    step(0, 0, 8'h00, 1, 0, 8'h00);
    chk("coin_addr", mem_addr, 8'h30);
    chk("coin_read", mem_read, 1);
    step(0, 0, 8'h00, 0, 0, 8'h00);
    chk("ign_done_addr", mem_addr, 8'h30);
    chk("ign_done_read", mem_read, 1);

    // Redirect with response to 8'hFF, then wrap to 8'h00
    step(0, 1, 8'hEE, 0, 1, 8'hFF);
    chk("rdr_resp_ir_load", ir_load, 0);
    step(0, 1, 8'h77, 0, 0, 8'h00);
    chk("wrap_addr_ff", mem_addr, 8'hFF);
    chk("wrap_load_ff", ir_load, 1);
    step(0, 0, 8'h00, 1, 0, 8'h00);
    chk("wrap_pc_ff", pc, 8'hFF);
    step(0, 0, 8'h00, 0, 0, 8'h00);
    chk("wrap_addr_00", mem_addr, 8'h00);
    chk("wrap_read_00", mem_read, 1);

    // Reset during an outstanding read; late response must be ignored
    step(1, 0, 8'h00, 0, 0, 8'h00);
    chk("mrst_mem_read", mem_read, 0);
    chk("mrst_ir_load", ir_load, 0);
    chk("mrst_insn_valid", insn_valid, 0);
    step(0, 1, 8'hEE, 0, 0, 8'h00);
    chk("late_mem_read", mem_read, 1);
    chk("late_mem_addr", mem_addr, 8'h10);
    chk("late_ir_load", ir_load, 0);
    step(0, 1, 8'h55, 0, 0, 8'h00);
    chk("reissue_addr", mem_addr, 8'h10);
    chk("reissue_ir_load", ir_load, 1);
    chk("reissue_ir_data", ir_data, 8'h55);
    step(0, 0, 8'h00, 0, 0, 8'h00);
    chk("reissue_pc", pc, 8'h10);
    chk("reissue_valid", insn_valid, 1);

    // Randomized phase against the reference model
    step(1, 0, 8'h00, 0, 0, 8'h00);
    step(1, 0, 8'h00, 0, 0, 8'h00);
    m_addr = 8'h10;
    m_pc   = 8'h10;
    m_insn = 1'b0;
    rq.delete();
    mreq   = 1'b0;
    mwait  = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      rst      = 1'b0;
      mem_resp = 1'b0;
      if (!m_insn) begin
        if (!mreq) begin
          mreq  = 1'b1;
          mwait = $urandom_range(0, 3);
        end
        if (mwait == 0) begin
          mem_resp = 1'b1;
          mreq     = 1'b0;
        end else begin
          mwait--;
        end
      end
      mem_rdata   = 8'($urandom_range(0, 255));
      exec_done   = ($urandom_range(0, 1) == 1);
      redirect    = ($urandom_range(0, 4) == 0);
      redirect_pc = 8'($urandom_range(0, 255));
      #1;
      exp_load = !m_insn && mem_resp && !redirect && (rq.size() == 0);
      chk("rnd_mem_read", mem_read, {7'd0, !m_insn});
      if (!m_insn) chk("rnd_mem_addr", mem_addr, m_addr);
      chk("rnd_ir_load", ir_load, {7'd0, exp_load});
      if (exp_load) chk("rnd_ir_data", ir_data, mem_rdata);
      chk("rnd_insn_valid", insn_valid, {7'd0, m_insn});
      chk("rnd_pc", pc, m_pc);

      if (!m_insn) begin
        if (mem_resp) begin
          if (redirect) begin
            m_addr = redirect_pc;
            rq.delete();
          end else if (rq.size() != 0) begin
            m_addr = rq[$];
            rq.delete();
          end else begin
            m_pc   = m_addr;
            m_addr = m_addr + 8'd1;
            m_insn = 1'b1;
          end
        end else if (redirect) begin
          rq.push_back(redirect_pc);
        end
      end else begin
        if (exec_done) begin
          if (redirect) m_addr = redirect_pc;
          else if (rq.size() != 0) m_addr = rq[$];
          rq.delete();
          m_insn = 1'b0;
        end else if (redirect) begin
          rq.push_back(redirect_pc);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
